// File: rtl/fp_subtractor_seq.sv
// rtl/fp_subtractor_seq.sv - multi-cycle IEEE-754 single-precision subtractor, Diff = A - B
// Optional ROUND_NEAREST_EN: round-to-nearest-even in one extra cycle; default rounds toward zero.
module fp_subtractor_seq #(
  parameter int ALIGN_STEP = 1,
  parameter int MAX_SHAMT  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Diff,
  output logic        Borrow,
  output logic        Zero,
  output logic        Ovf
);

  // Significands carry guard/round/sticky below the 24-bit field so truncation is exact RTZ.
  localparam int         SW     = 27;
  localparam logic [7:0] MAX_SH = 8'(MAX_SHAMT);

  typedef enum logic [2:0] {
    IDLE, SWAP, ALIGN, ADDSUB, NORM, RND, PACK, DONE
  } state_t;

  state_t        state;
  logic [31:0]   a_q, b_q;
  logic          sign_l, sign_s;
  logic [9:0]    exp_r;
  logic [7:0]    shamt;
  logic [SW-1:0] sig_l, sig_s;
  logic [SW:0]   sum;

  function automatic logic [SW-1:0] sig_of(input logic [30:0] mag);
    return (mag[30:23] == 8'd0) ? '0 : {1'b1, mag[22:0], 3'b000};
  endfunction

  logic [30:0] mag_a, mag_b, mag_l, mag_s;
  logic        b_gt;
  logic [7:0]  exp_diff;

  always_comb begin
    mag_a    = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
    mag_b    = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
    b_gt     = mag_b > mag_a;
    mag_l    = b_gt ? mag_b : mag_a;
    mag_s    = b_gt ? mag_a : mag_b;
    exp_diff = mag_l[30:23] - mag_s[30:23];
  end

  logic [SW-1:0] align_sig;
  logic [7:0]    align_sh;

  // Right shift keeps the OR of everything shifted out in bit 0 (sticky).
  always_comb begin
    align_sig = sig_s;
    align_sh  = shamt;
    for (int i = 0; i < ALIGN_STEP; i++) begin
      if (align_sh != 8'd0) begin
        align_sig = {1'b0, align_sig[SW-1:2], align_sig[1] | align_sig[0]};
        align_sh  = align_sh - 8'd1;
      end
    end
  end

  logic [SW:0] sum_next;

  always_comb begin
    if (sign_l == sign_s) sum_next = {1'b0, sig_l} + {1'b0, sig_s};
    else                  sum_next = {1'b0, sig_l} - {1'b0, sig_s};
  end

  logic [SW:0] norm_sum;
  logic [9:0]  norm_exp;
  logic        norm_done;

  always_comb begin
    norm_sum = sum;
    norm_exp = exp_r;
    if (sum[SW]) begin
      norm_sum = {1'b0, sum[SW:2], sum[1] | sum[0]};
      norm_exp = exp_r + 10'd1;
    end else begin
      for (int i = 0; i < ALIGN_STEP; i++) begin
        if (!norm_sum[SW-1] && norm_exp > 10'd1) begin
          norm_sum = norm_sum << 1;
          norm_exp = norm_exp - 10'd1;
        end
      end
    end
    norm_done = norm_sum[SW-1] || (norm_exp <= 10'd1);
  end

`ifdef ROUND_NEAREST_EN
  logic [24:0] rnd_man;
  logic        rnd_up;

  always_comb begin
    rnd_up  = sum[2] & (sum[1] | sum[0] | sum[3]);
    rnd_man = {1'b0, sum[SW-1:3]} + {24'd0, rnd_up};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Diff      <= 32'd0;
      Borrow    <= 1'b0;
      Zero      <= 1'b0;
      Ovf       <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      exp_r     <= 10'd0;
      shamt     <= 8'd0;
      sig_l     <= '0;
      sig_s     <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= {~B[31], B[30:0]};
            in_ready <= 1'b0;
            state    <= SWAP;
          end
        end
        SWAP: begin
          Borrow <= b_gt;
          sign_l <= b_gt ? b_q[31] : a_q[31];
          sign_s <= b_gt ? a_q[31] : b_q[31];
          exp_r  <= {2'b00, mag_l[30:23]};
          shamt  <= (exp_diff > MAX_SH) ? MAX_SH : exp_diff;
          sig_l  <= sig_of(mag_l);
          sig_s  <= sig_of(mag_s);
          state  <= ALIGN;
        end
        ALIGN: begin
          sig_s <= align_sig;
          shamt <= align_sh;
          if (align_sh == 8'd0) state <= ADDSUB;
        end
        ADDSUB: begin
          sum   <= sum_next;
          state <= (sum_next == '0) ? PACK : NORM;
        end
        NORM: begin
          sum   <= norm_sum;
          exp_r <= norm_exp;
          if (norm_done) begin
`ifdef ROUND_NEAREST_EN
            state <= RND;
`else
            state <= PACK;
`endif
          end
        end
`ifdef ROUND_NEAREST_EN
        RND: begin
          if (rnd_man[24]) begin
            sum   <= {1'b0, rnd_man[24:1], 3'b000};
            exp_r <= exp_r + 10'd1;
          end else begin
            sum   <= {1'b0, rnd_man[23:0], 3'b000};
          end
          state <= PACK;
        end
`endif
        PACK: begin
          out_valid <= 1'b1;
          Zero      <= 1'b0;
          Ovf       <= 1'b0;
          // An unnormalised significand here means the true exponent fell below 1.
          if (!sum[SW-1]) begin
            Diff <= 32'd0;
            Zero <= 1'b1;
          end else if (exp_r >= 10'd255) begin
            Diff <= {sign_l, 8'hFF, 23'd0};
            Ovf  <= 1'b1;
          end else begin
            Diff <= {sign_l, exp_r[7:0], sum[SW-2:3]};
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb/tb_fp_subtractor_seq.sv - scoreboard bench for fp_subtractor_seq
// Expected results come from exact integer arithmetic on the operands, truncated toward zero.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        in_ready, out_valid, Borrow, Zero, Ovf;
  logic [31:0] Diff;

  int checks = 0;
  int passed = 0;
  bit hold_ready = 1'b0;

  typedef struct packed {
    logic [31:0] d;
    logic        bw;
    logic        z;
    logic        o;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  fp_subtractor_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Borrow   (Borrow),
    .Zero     (Zero),
    .Ovf      (Ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t         r;
    logic [127:0] va, vb, mag, man;
    int           ea, eb, emin, p, e;
    logic         sa, sb, neg;
    r  = '0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    va = (ea == 0) ? 128'd0 : 128'({1'b1, a[22:0]});
    vb = (eb == 0) ? 128'd0 : 128'({1'b1, b[22:0]});
    sa = a[31];
    sb = ~b[31];
    if (ea == 0 && eb == 0) emin = 1;
    else if (ea == 0)       emin = eb;
    else if (eb == 0)       emin = ea;
    else                    emin = (ea < eb) ? ea : eb;
    if (ea != 0) va = va << (ea - emin);
    if (eb != 0) vb = vb << (eb - emin);
    r.bw = (vb > va);
    if (sa == sb)       begin mag = va + vb; neg = sa; end
    else if (va >= vb)  begin mag = va - vb; neg = sa; end
    else                begin mag = vb - va; neg = sb; end
    if (mag == 0) begin
      r.z = 1'b1;
      return r;
    end
    p = 127;
    while (!mag[p]) p--;
    e = emin + p - 23;
    if (e >= 255) begin
      r.d = {neg, 8'hFF, 23'd0};
      r.o = 1'b1;
    end else if (e < 1) begin
      r.z = 1'b1;
    end else begin
      man = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
      r.d = {neg, 8'(e), man[22:0]};
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: in_ready %b, expected 1", in_ready);
      return;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    q.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Monitor: drives random backpressure, pops the scoreboard on each handshake,
  // and requires held outputs to stay stable while out_ready is low.
  initial begin
    res_t got, want, last;
    bit   last_valid = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
        last_valid = 1'b0;
        continue;
      end
      got = {Diff, Borrow, Zero, Ovf};
      if (last_valid && out_valid) check("hold_stable", got, last);
      last_valid = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got %h, expected none", got);
          end else begin
            want = q.pop_front();
            check("result", got, want);
          end
        end else begin
          last = got;
          last_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    int          ea, eb, n;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", Diff, 0);
    check("rst_borrow", Borrow, 0);
    check("rst_zero", Zero, 0);
    check("rst_ovf", Ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h40400000, 32'h3F800000);
    issue(32'h3F800000, 32'h40400000);
    issue(32'h3F800000, 32'h3F800000);
    issue(32'h7F7FFFFF, 32'hFF7FFFFF);
    issue(32'h3F800000, 32'h33800000);
    issue(32'h00800001, 32'h00800000);
    issue(32'h00000000, 32'h3F800000);

    // A second operand pair offered mid-ALIGN must be dropped.
    issue(32'h3F800000, 32'h33800000);
    repeat (3) @(negedge clk);
    check("in_ready_busy", in_ready, 0);
    A = 32'h40400000;
    B = 32'h3F800000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;

    issue(32'hC1200000, 32'h40A00000);
    hold_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_valid", out_valid, 1);
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;

    // Long NORM run (massive cancellation), aborted by reset.
    issue(32'h3F800000, 32'h3F7FFFFF);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_diff", Diff, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    for (int i = 0; i < 200; i++) begin
      a  = $urandom;
      b  = $urandom;
      ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1)   eb = 1;
      if (eb > 254) eb = 254;
      a[30:23] = 8'(ea);
      b[30:23] = 8'(eb);
      case ($urandom_range(0, 11))
        0: a[30:23] = 8'd0;
        1: b[30:23] = 8'd0;
        2: b = a;
        3: b = a ^ 32'h80000000;
        4: b[30:0] = a[30:0] ^ 31'(1 << $urandom_range(0, 22));
        default: ;
      endcase
      issue(a, b);
    end

    n = 0;
    while ((q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
